// File: rtl/mem_stage_requester.sv
// mem_stage_requester
//   Initiator side of the SEQ data-memory interface. Takes one decoded
//   instruction's memory operands from execute, selects the address, data
//   and direction for the opcode, range-checks the address, and issues one
//   read or write request over a req/ack handshake. Returns Value_M and a
//   memory status to write-back / PC-update.
//
//   Optional build macro: MEM_TIMEOUT_EN
//     When defined, a request that sees no mem_ack for TIMEOUT_CYCLES
//     cycles is aborted with mem_stat = TIMEOUT. Otherwise REQ waits
//     indefinitely for mem_ack.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start                      one-cycle pulse, operands valid
//   Ins_Code                   instruction icode
//   instruction_invalid_check  1 = icode invalid, no access performed
//   value_A, Value_E, Val_P    operand values from decode/execute
//   busy                       high from accepted start until done
//   done                       one-cycle pulse, results valid
//   Value_M                    read data, held until the next completed read
//   mem_stat                   0 OK, 1 ADR, 2 TIMEOUT, 3 INS
//   mem_req, mem_we            request / direction to the memory responder
//   mem_addr, mem_wdata        request address and write data
//   mem_ack, mem_rdata         responder acknowledge and read data

module mem_stage_requester #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned ADDR_LIMIT     = 4095,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        Ins_Code,
  input  logic              instruction_invalid_check,
  input  logic [DATA_W-1:0] value_A,
  input  logic [DATA_W-1:0] Value_E,
  input  logic [DATA_W-1:0] Val_P,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Value_M,
  output logic [1:0]        mem_stat,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam logic [1:0] STAT_OK  = 2'd0;
  localparam logic [1:0] STAT_ADR = 2'd1;
  localparam logic [1:0] STAT_TMO = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [DATA_W-1:0] LIMIT = DATA_W'(ADDR_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_d;

  logic              busy_d, done_d, req_d, we_d;
  logic [DATA_W-1:0] addr_d, wdata_d, valm_d;
  logic [1:0]        stat_d;

  // Per-opcode operand selection
  logic              is_mem;
  logic              sel_we;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt, cnt_d;
`endif

  always_comb begin
    is_mem    = 1'b1;
    sel_we    = 1'b0;
    sel_addr  = Value_E;
    sel_wdata = '0;
    unique case (Ins_Code)
      I_RMMOVQ: begin sel_we = 1'b1; sel_wdata = value_A; end
      I_MRMOVQ: sel_we = 1'b0;
      I_CALL:   begin sel_we = 1'b1; sel_wdata = Val_P; end
      I_PUSHQ:  begin sel_we = 1'b1; sel_wdata = value_A; end
      I_POPQ:   sel_addr = value_A;
      I_RET:    sel_addr = value_A;
      default:  is_mem = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state;
    busy_d  = busy;
    done_d  = 1'b0;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    valm_d  = Value_M;
    stat_d  = mem_stat;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (instruction_invalid_check) begin
            stat_d  = STAT_INS;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (!is_mem) begin
            stat_d  = STAT_OK;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (sel_addr > LIMIT) begin
            // Unsigned compare: negative addresses (MSB set) land here too
            stat_d  = STAT_ADR;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = sel_we;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            stat_d  = STAT_OK;
            state_d = S_REQ;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      S_REQ: begin
        // Ack takes priority over the timeout limit in the same cycle
        if (mem_ack) begin
          req_d = 1'b0;
          if (!mem_we) valm_d = mem_rdata;
          stat_d  = STAT_OK;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          req_d   = 1'b0;
          stat_d  = STAT_TMO;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
`endif
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      Value_M   <= '0;
      mem_stat  <= STAT_OK;
    end else begin
      state     <= state_d;
      busy      <= busy_d;
      done      <= done_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      Value_M   <= valm_d;
      mem_stat  <= stat_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_d;
  end
`endif

endmodule

// File: doc/mem_stage_requester.md
Name: mem_stage_requester

Overview:
- Initiator side of the SEQ data-memory interface: takes one decoded instruction's memory operands from execute, issues a single read or write request to the data-memory responder over a req/ack handshake, and returns Value_M plus a memory status to write-back/PC-update.
- Owns the per-opcode address/data selection, the address-range check and request sequencing, so the memory array only sees legal, stable requests.

Parameters:
ADDR_LIMIT, 4095, highest legal word address (unsigned); higher addresses are rejected without a request
DATA_W, 64, width of data and address buses
TIMEOUT_CYCLES, 16, cycles in REQ without ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse: operands valid, begin memory stage
Ins_Code  in  4  instruction icode
instruction_invalid_check  in  1  1 = icode invalid; no access performed
value_A  in  DATA_W  valA (store data; address for popq/ret)
Value_E  in  DATA_W  valE (address for rmmovq/mrmovq/call/pushq)
Val_P  in  DATA_W  return address stored by call
busy  out  1  1 from accepted start until done
done  out  1  one-cycle pulse: results valid
Value_M  out  DATA_W  read data; held until next completed read
mem_stat  out  2  0 OK, 1 ADR (address exceeded), 2 TIMEOUT, 3 INS
mem_req  out  1  request to memory responder
mem_we  out  1  1 write, 0 read; valid while mem_req
mem_addr  out  DATA_W  request address
mem_wdata  out  DATA_W  write data
mem_ack  in  1  responder accepted/completed request (may be same cycle as mem_req)
mem_rdata  in  DATA_W  read data, valid while mem_ack and mem_we=0

Behaviour:
- Reset (async, any state): state IDLE; busy, done, mem_req, mem_we = 0; mem_addr, mem_wdata, Value_M = 0; mem_stat = 0. A request in flight is dropped; no completion reported.
- States: IDLE, REQ, DONE. All outputs registered.
- IDLE: start sampled high -> latch inputs, busy=1, then, by priority:
  - instruction_invalid_check=1 -> DONE, mem_stat=INS.
  - Ins_Code not in {4,5,8,9,10,11} -> DONE, mem_stat=OK.
  - selected address > ADDR_LIMIT (unsigned) -> DONE, mem_stat=ADR; mem_req never asserted.
  - otherwise -> REQ with mem_req=1 and the address/data/we values below.
- Opcode selection:
  - 4 rmmovq: write, addr=Value_E, data=value_A.
  - 5 mrmovq: read, addr=Value_E.
  - 8 call: write, addr=Value_E, data=Val_P.
  - 10 pushq: write, addr=Value_E, data=value_A.
  - 11 popq: read, addr=value_A.
  - 9 ret: read, addr=value_A.
- REQ: mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack is sampled high. On ack: for a read, Value_M <= mem_rdata; mem_req=0; mem_stat=OK; -> DONE.
- DONE: done=1 for exactly one cycle, busy=0 on exit, -> IDLE. mem_stat remains valid until the next start.
- Value_M changes only on a completed read; writes, no-access ops and errors leave it unchanged.
- start while busy=1 is ignored; no queueing.
- Latency from the start edge to done high:
  - 1 cycle for no-access, INS and ADR cases.
  - 1 + (cycles in REQ) for access cases; a zero-wait responder gives done 2 cycles after start.
- Address ADDR_LIMIT itself is legal; ADDR_LIMIT+1 and any negative (MSB set) value are ADR.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a counter clears on entering REQ and increments each REQ cycle without ack. On reaching TIMEOUT_CYCLES: drop mem_req, mem_stat=TIMEOUT, Value_M unchanged, -> DONE. If ack and the limit arrive in the same cycle, ack wins.
- Undefined: no counter; REQ waits indefinitely for mem_ack; mem_stat never reports TIMEOUT.

Test Plan:
- rmmovq: Ins_Code=4, Value_E=100, value_A=-5, ack 1 cycle after req -> mem_req/mem_we=1, mem_addr=100, mem_wdata=-5 held; done 3 cycles after start; mem_stat=0; Value_M unchanged.
- mrmovq then popq: Value_E=4095 with rdata=77, then value_A=20 with rdata=21, both zero-wait -> mem_we=0; Value_M=77 then 21; done 2 cycles after each start.
- Range and invalid: rmmovq Value_E=4096; then call Value_E=-8 -> no mem_req, done after 1 cycle, mem_stat=1; icode invalid flag=1 -> mem_stat=3, no mem_req.
- No-access and busy: Ins_Code=6 -> done after 1 cycle, mem_stat=0; second start during REQ of a call (Val_P=0x40) -> ignored; only one write, mem_wdata=0x40.
- Reset mid-REQ: assert rst while mem_req=1 and before ack -> mem_req, busy, done drop immediately; after release, a new ret (value_A=8, rdata=12) completes normally with Value_M=12.
- With MEM_TIMEOUT_EN: pushq, ack never asserted -> mem_req high for exactly 16 cycles, then mem_stat=2 and done pulse; without the macro, mem_req stays high at cycle 40.
